// File: rtl/search_window_capture_pkg.sv
// -----------------------------------------------------------------------------
// search_window_capture_pkg
// Shared definitions for the template capture block: default pixel width,
// camera coordinate width, default frame dimensions, FSM state encoding and
// the window range-check helper.
// -----------------------------------------------------------------------------
package search_window_capture_pkg;

  localparam int COORD_W     = 13;
  localparam int PIX_W_DEF   = 10;
  localparam int FRAME_W_DEF = 800;
  localparam int FRAME_H_DEF = 600;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READY   = 2'd3
  } state_t;

  // True when a template of 'tpl' pixels starting at 'org' stays inside a
  // frame dimension of 'frame' pixels.
  function automatic logic window_fits(input logic [COORD_W-1:0] org,
                                       input int tpl, input int frame);
    return (int'(org) + tpl) <= frame;
  endfunction

endpackage

// File: rtl/search_window_ram.sv
// -----------------------------------------------------------------------------
// search_window_ram
// Simple dual-port RAM holding the captured template: one write port and one
// read port with a registered output (1-cycle read latency). Contents are
// never cleared.
// Ports:
//   clk  in   1   clock
//   we   in   1   write enable
//   wa   in   AW  write address
//   wd   in   DW  write data
//   ra   in   AW  read address
//   q    out  DW  read data, registered
// -----------------------------------------------------------------------------
module search_window_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    q <= mem[ra];
  end

endmodule

// File: rtl/search_window_capture.sv
// -----------------------------------------------------------------------------
// search_window_capture
// Captures a TPL_W x TPL_H template patch from the live camera pixel stream
// into on-chip RAM and serves registered (x,y) reads to the correlation
// scorer. oReady tells the search controller that a complete template is held.
//
// Optional feature macro: TEMPLATE_SUM_EN
//   defined   -> oSum carries the sum of all template pixels (valid while
//                oReady=1, held until the next accepted iStart)
//   undefined -> oSum tied to 0
//
// Ports:
//   iCLK       in   1       system clock
//   iRST       in   1       asynchronous active-high reset
//   iStart     in   1       pulse: arm capture at (iXorigin,iYorigin)
//   iXorigin   in   13      window top-left X, sampled with iStart
//   iYorigin   in   13      window top-left Y, sampled with iStart
//   iDVAL      in   1       camera pixel valid
//   iX, iY     in   13      camera pixel column / row
//   iPixel     in   PIX_W   camera pixel value
//   iRdX, iRdY in   13      template read column / row
//   oRdData    out  PIX_W   template pixel, 1-cycle latency
//   oRdOOR     out  1       read out of range, aligned with oRdData
//   oReady     out  1       level: template complete and valid
//   oErr       out  1       pulse: iStart rejected, window outside frame
//   oSum       out  SUM_W   template pixel sum
//   dbg_state  out  2       current FSM state
//
// Handshake: there is no back-pressure anywhere. iStart is a one-cycle
// request that is either accepted (state IDLE/READY, window fits), rejected
// with an oErr pulse (IDLE/READY, window does not fit) or silently dropped
// (ARM/CAPTURE). Camera pixels are qualified only by iDVAL; cycles with
// iDVAL=0 are ignored. Reads are always accepted and return one cycle later.
// -----------------------------------------------------------------------------
module search_window_capture
  import search_window_capture_pkg::*;
#(
  parameter int TPL_W   = 32,
  parameter int TPL_H   = 32,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF,
  parameter int PIX_W   = PIX_W_DEF
) (
  input  logic                                      iCLK,
  input  logic                                      iRST,
  input  logic                                      iStart,
  input  logic [COORD_W-1:0]                        iXorigin,
  input  logic [COORD_W-1:0]                        iYorigin,
  input  logic                                      iDVAL,
  input  logic [COORD_W-1:0]                        iX,
  input  logic [COORD_W-1:0]                        iY,
  input  logic [PIX_W-1:0]                          iPixel,
  input  logic [COORD_W-1:0]                        iRdX,
  input  logic [COORD_W-1:0]                        iRdY,
  output logic [PIX_W-1:0]                          oRdData,
  output logic                                      oRdOOR,
  output logic                                      oReady,
  output logic                                      oErr,
  output logic [PIX_W+$clog2(TPL_W*TPL_H)-1:0]      oSum,
  output state_t                                    dbg_state
);

  localparam int N     = TPL_W * TPL_H;
  localparam int LW    = $clog2(TPL_W);
  localparam int LH    = $clog2(TPL_H);
  localparam int AW    = LW + LH;
  localparam int CW    = AW + 1;
  localparam int SUM_W = PIX_W + AW;

  state_t             state;
  logic [COORD_W-1:0] x0, y0;
  logic [CW-1:0]      count;

  // ---------------------------------------------------------------- capture
  logic               sof;
  logic [COORD_W-1:0] x_off, y_off;
  logic               in_win;
  logic               capturing;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [CW-1:0]      count_next;
  logic               done;
  logic               start_ok;

  assign sof   = iDVAL && (iX == '0) && (iY == '0);
  assign x_off = iX - x0;
  assign y_off = iY - y0;

  assign in_win = iDVAL &&
                  (iX >= x0) && (x_off < COORD_W'(TPL_W)) &&
                  (iY >= y0) && (y_off < COORD_W'(TPL_H));

  // The start-of-frame pixel that releases ARM is itself a capture pixel.
  assign capturing = (state == ST_CAPTURE) || ((state == ST_ARM) && sof);
  assign wr_en     = capturing && in_win;
  assign wr_addr   = {y_off[LH-1:0], x_off[LW-1:0]};

  // A new frame start restarts the fill so the template never mixes frames.
  assign count_next = (sof ? '0 : count) + CW'(wr_en);
  assign done       = (count_next == CW'(N));

  assign start_ok = window_fits(iXorigin, TPL_W, FRAME_W) &&
                    window_fits(iYorigin, TPL_H, FRAME_H);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_IDLE;
      x0    <= '0;
      y0    <= '0;
      count <= '0;
      oErr  <= 1'b0;
    end else begin
      oErr <= 1'b0;
      case (state)
        ST_IDLE, ST_READY: begin
          if (iStart) begin
            if (start_ok) begin
              x0    <= iXorigin;
              y0    <= iYorigin;
              count <= '0;
              state <= ST_ARM;
            end else begin
              oErr <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (sof) begin
            count <= count_next;
            state <= done ? ST_READY : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (iDVAL) begin
            count <= count_next;
            if (done) state <= ST_READY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oReady    = (state == ST_READY);
  assign dbg_state = state;

  // ---------------------------------------------------------------- sum
`ifdef TEMPLATE_SUM_EN
  logic [SUM_W-1:0] sum;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sum <= '0;
    end else if (((state == ST_IDLE) || (state == ST_READY)) && iStart && start_ok) begin
      sum <= '0;
    end else if (capturing && iDVAL) begin
      // Restart together with the pixel counter on a new frame start.
      sum <= (sof ? '0 : sum) + (wr_en ? SUM_W'(iPixel) : '0);
    end
  end

  assign oSum = sum;
`else
  assign oSum = '0;
`endif

  // ---------------------------------------------------------------- reads
  logic [AW-1:0]    rd_addr;
  logic             rd_oor;
  logic             rd_valid;
  logic [PIX_W-1:0] ram_q;

  assign rd_addr = {iRdY[LH-1:0], iRdX[LW-1:0]};
  assign rd_oor  = (iRdX >= COORD_W'(TPL_W)) || (iRdY >= COORD_W'(TPL_H));

  // Masks are registered alongside the RAM read so they line up with ram_q.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_valid <= 1'b0;
      oRdOOR   <= 1'b0;
    end else begin
      rd_valid <= (state == ST_READY) && !rd_oor;
      oRdOOR   <= (state == ST_READY) && rd_oor;
    end
  end

  assign oRdData = rd_valid ? ram_q : '0;

  search_window_ram #(
    .DEPTH (N),
    .AW    (AW),
    .DW    (PIX_W)
  ) u_ram (
    .clk (iCLK),
    .we  (wr_en),
    .wa  (wr_addr),
    .wd  (iPixel),
    .ra  (rd_addr),
    .q   (ram_q)
  );

endmodule

// File: tb/tb_search_window_capture.sv
module tb_search_window_capture;
  import search_window_capture_pkg::*;

  localparam int TW = 32;
  localparam int TH = 32;
  localparam int N  = TW * TH;

  logic        iCLK;
  logic        iRST;
  logic        iStart;
  logic [12:0] iXorigin, iYorigin;
  logic        iDVAL;
  logic [12:0] iX, iY;
  logic [9:0]  iPixel;
  logic [12:0] iRdX, iRdY;
  logic [9:0]  oRdData;
  logic        oRdOOR;
  logic        oReady;
  logic        oErr;
  logic [19:0] oSum;
  state_t      dbg_state;

  search_window_capture #(
    .TPL_W(TW), .TPL_H(TH), .FRAME_W(800), .FRAME_H(600), .PIX_W(10)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart),
    .iXorigin(iXorigin), .iYorigin(iYorigin),
    .iDVAL(iDVAL), .iX(iX), .iY(iY), .iPixel(iPixel),
    .iRdX(iRdX), .iRdY(iRdY),
    .oRdData(oRdData), .oRdOOR(oRdOOR), .oReady(oReady), .oErr(oErr),
    .oSum(oSum), .dbg_state(dbg_state)
  );

  // ------------------------------------------------------------ clock/reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ------------------------------------------------------------ model
  // Template as a plain pixel array plus three phase flags: waiting for a
  // frame start, filling, and holding a complete template.
  int         ncmp  = 0;
  int         nfail = 0;
  bit         chk_en = 1'b0;
  bit         mdl_ready = 1'b0, mdl_wait = 1'b0, mdl_fill = 1'b0;
  int         mdl_x0 = 0, mdl_y0 = 0, mdl_cnt = 0;
  logic [19:0] mdl_sum = '0;
  logic [9:0] mdl_mem [N];
  logic       exp_err = 1'b0, exp_oor = 1'b0;
  logic [9:0] exp_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic state_t exp_state();
    if (mdl_ready) return ST_READY;
    if (mdl_fill)  return ST_CAPTURE;
    if (mdl_wait)  return ST_ARM;
    return ST_IDLE;
  endfunction

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic step();
    int rx, ry, px, py;
    if (iRST) begin
      mdl_ready = 0; mdl_wait = 0; mdl_fill = 0; mdl_sum = '0;
      exp_err = 0; exp_rd = '0; exp_oor = 0;
      return;
    end
    rx = int'(iRdX); ry = int'(iRdY);
    if (!mdl_ready) begin
      exp_rd = '0; exp_oor = 0;
    end else if (rx >= TW || ry >= TH) begin
      exp_rd = '0; exp_oor = 1;
    end else begin
      exp_rd = mdl_mem[ry * TW + rx]; exp_oor = 0;
    end
    exp_err = 0;
    if (iStart && !mdl_wait && !mdl_fill) begin
      if (int'(iXorigin) + TW > 800 || int'(iYorigin) + TH > 600) begin
        exp_err = 1;
      end else begin
        mdl_x0 = int'(iXorigin); mdl_y0 = int'(iYorigin);
        mdl_ready = 0; mdl_wait = 1; mdl_cnt = 0; mdl_sum = '0;
      end
    end else if (iDVAL && (mdl_wait || mdl_fill)) begin
      px = int'(iX); py = int'(iY);
      if (px == 0 && py == 0) begin
        mdl_wait = 0; mdl_fill = 1; mdl_cnt = 0; mdl_sum = '0;
      end
      if (mdl_fill && px >= mdl_x0 && px < mdl_x0 + TW && py >= mdl_y0 && py < mdl_y0 + TH) begin
        mdl_mem[(py - mdl_y0) * TW + (px - mdl_x0)] = iPixel;
        mdl_cnt++;
        mdl_sum = mdl_sum + 20'(iPixel);
        if (mdl_cnt == N) begin
          mdl_fill = 0; mdl_ready = 1;
        end
      end
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  always @(posedge iCLK) begin
    #2;
    if (chk_en) begin
      check("ready", oReady, mdl_ready);
      check("err", oErr, exp_err);
      check("rd_data", oRdData, exp_rd);
      check("rd_oor", oRdOOR, exp_oor);
      check("state", dbg_state, exp_state());
`ifdef TEMPLATE_SUM_EN
      if (mdl_ready) check("sum", oSum, mdl_sum);
`else
      check("sum", oSum, 0);
`endif
    end
  end

  // ------------------------------------------------------------ drivers
  task automatic cyc();
    step();
    @(negedge iCLK);
  endtask

  function automatic logic [9:0] pix(input int patt, input int x, input int y);
    case (patt)
      0:       return 10'((x + y) & 32'h3FF);
      1:       return 10'(((x * 5) ^ (y * 3)) & 32'h3FF);
      default: return 10'd4;
    endcase
  endfunction

  task automatic send_pix(input int x, input int y, input int patt, input int gap);
    iDVAL = 1'b1; iX = 13'(x); iY = 13'(y); iPixel = pix(patt, x, y);
    cyc();
    for (int g = 0; g < gap; g++) begin
      iDVAL = 1'b0;
      iX = 13'($urandom_range(0, 3)); iY = 13'($urandom_range(0, 3));
      iPixel = 10'($urandom_range(0, 1023));
      cyc();
    end
    iDVAL = 1'b0;
  endtask

  task automatic start(input int x, input int y);
    iStart = 1'b1; iXorigin = 13'(x); iYorigin = 13'(y);
    cyc();
    iStart = 1'b0;
  endtask

  // Frame start pixel, then rows ylo..yhi x cols xlo..xhi. Stops early once
  // the model has seen stop_cnt writes (0 = never).
  task automatic stream(input int xlo, input int xhi, input int ylo, input int yhi,
                        input int patt, input int gap, input int stop_cnt, input bit sof);
    if (sof) send_pix(0, 0, patt, gap);
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        if (stop_cnt > 0 && mdl_cnt >= stop_cnt) return;
        send_pix(x, y, patt, gap);
        if (x == 131 && y == 81 && mdl_x0 == 100 && mdl_y0 == 50)
          check("ready_after_131_81", oReady, 1);
      end
    end
  endtask

  task automatic read(input int x, input int y);
    iRdX = 13'(x); iRdY = 13'(y);
    cyc();
  endtask

  task automatic read_all();
    for (int y = 0; y < TH; y++)
      for (int x = 0; x < TW; x++)
        read(x, y);
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    iRST = 1'b1; iStart = 1'b0; iXorigin = '0; iYorigin = '0;
    iDVAL = 1'b0; iX = '0; iY = '0; iPixel = '0; iRdX = '0; iRdY = '0;
    step();
    @(negedge iCLK);
    chk_en = 1'b1;
    cyc(); cyc();
    check("reset_ready", oReady, 0);
    check("reset_err", oErr, 0);
    check("reset_rd_data", oRdData, 0);
    check("reset_rd_oor", oRdOOR, 0);
    check("reset_sum", oSum, 0);
    check("reset_state", dbg_state, ST_IDLE);
    iRST = 1'b0;
    cyc();

    // Reset in the middle of a capture after 100 writes.
    start(100, 50);
    stream(100, 131, 50, 81, 0, 0, 100, 1'b1);
    iRdX = 13'd5; iRdY = 13'd7;
    iRST = 1'b1;
    cyc();
    check("midrst_ready", oReady, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_rd_data", oRdData, 0);
    iRST = 1'b0;
    cyc();

    // Full capture at (100,50) with margin pixels around the window.
    start(100, 50);
    check("armed_state", dbg_state, ST_ARM);
    stream(98, 133, 49, 82, 0, 0, 0, 1'b1);
    read(5, 7);
    check("rd_5_7", oRdData, 162);
    read(32, 0);
    check("rd_32_0_data", oRdData, 0);
    check("rd_32_0_oor", oRdOOR, 1);
    read(31, 31);
    check("rd_31_31_data", oRdData, 212);
    check("rd_31_31_oor", oRdOOR, 0);
    read(0, 32); read(8191, 8191); read(0, 0);
    read_all();

    // Window that does not fit horizontally: rejected, template kept.
    start(790, 10);
    check("err_pulse", oErr, 1);
    check("err_ready_kept", oReady, 1);
    cyc();
    check("err_cleared", oErr, 0);
    start(10, 569);
    start(0, 568);
    check("err_fit_edge", oErr, 0);

    // Sparse valid (1 of 3), partial frame, ignored start, then frame restart.
    stream(0, 31, 568, 575, 1, 2, 0, 1'b1);
    start(790, 10);
    check("start_in_capture_no_err", oErr, 0);
    stream(0, 31, 568, 599, 1, 2, 0, 1'b1);
    read_all();
    read(3, 4);
    check("rd_3_4_patt1", oRdData, 10'(((3 * 5) ^ (572 * 3)) & 32'h3FF));

`ifdef TEMPLATE_SUM_EN
    start(200, 300);
    stream(200, 231, 300, 331, 2, 0, 0, 1'b1);
    check("sum_const4", oSum, 4096);
`endif

    cyc(); cyc();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
